// File: rtl/ieee_rom_arbiter.sv
// Time-slot arbiter that lets NCLI drive CPUs share one synchronous ROM.
// Each ph2 frame scans every client once, skips cached hits, and captures returning ROM data.
module ieee_rom_arbiter #(
   parameter int NCLI = 4,
   parameter int AW   = 14,
   parameter int DW   = 8,
   parameter int RLAT = 1,
   localparam int SW  = (NCLI > 1) ? $clog2(NCLI) : 1
) (
   input  logic               clk_sys,
   input  logic               reset,
   input  logic               ph2,
   input  logic [NCLI-1:0]    cli_en,
   input  logic [NCLI*AW-1:0] cli_addr,
   input  logic               invalidate,
   output logic [AW-1:0]      rom_addr,
   output logic [SW-1:0]      rom_sel,
   input  logic [DW-1:0]      rom_q,
   output logic [NCLI*DW-1:0] cli_data,
   output logic [NCLI-1:0]    cli_valid,
   output logic               busy,
   output logic               done,
   output logic               overrun
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

   state_t                     state_q;
   logic [SW-1:0]              ptr_q;
   logic [1:0]                 cnt_q;
   logic [NCLI-1:0][AW-1:0]    snap_addr_q;
   logic [NCLI-1:0][AW-1:0]    tag_q;
   logic [NCLI-1:0]            snap_en_q;
   logic [RLAT-1:0]            pipe_vld_q;
   logic [RLAT-1:0]            pipe_keep_q;
   logic [RLAT-1:0][SW-1:0]    pipe_idx_q;
   logic [RLAT-1:0][AW-1:0]    pipe_addr_q;
   logic                       miss_d;
   logic                       last_d;

   // A client needs a ROM read unless its cached tag already matches the snapshot address.
   always_comb begin
      miss_d = snap_en_q[ptr_q] &&
               !(cli_valid[ptr_q] && (tag_q[ptr_q] == snap_addr_q[ptr_q]));
      last_d = (ptr_q == SW'(NCLI - 1));
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         cnt_q       <= '0;
         snap_addr_q <= '0;
         snap_en_q   <= '0;
         tag_q       <= '0;
         pipe_vld_q  <= '0;
         pipe_keep_q <= '0;
         pipe_idx_q  <= '0;
         pipe_addr_q <= '0;
         rom_addr    <= '0;
         rom_sel     <= '0;
         cli_data    <= '0;
         cli_valid   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         done <= 1'b0;

         for (int i = RLAT - 1; i > 0; i--) begin
            pipe_vld_q[i]  <= pipe_vld_q[i-1];
            pipe_keep_q[i] <= pipe_keep_q[i-1] & ~invalidate;
            pipe_idx_q[i]  <= pipe_idx_q[i-1];
            pipe_addr_q[i] <= pipe_addr_q[i-1];
         end
         pipe_vld_q[0]  <= 1'b0;
         pipe_keep_q[0] <= 1'b0;
         pipe_idx_q[0]  <= '0;
         pipe_addr_q[0] <= '0;

         // The entry leaving the pipeline lines up with rom_q for the address it issued.
         if (pipe_vld_q[RLAT-1]) begin
            cli_data[pipe_idx_q[RLAT-1]*DW +: DW] <= rom_q;
            tag_q[pipe_idx_q[RLAT-1]]             <= pipe_addr_q[RLAT-1];
            cli_valid[pipe_idx_q[RLAT-1]]         <= pipe_keep_q[RLAT-1];
         end
         if (invalidate) begin
            cli_valid <= '0;
         end

         case (state_q)
            IDLE: begin
               if (ph2) begin
                  snap_en_q <= cli_en;
                  for (int c = 0; c < NCLI; c++) begin
                     snap_addr_q[c] <= cli_addr[c*AW +: AW];
                  end
                  ptr_q   <= '0;
                  busy    <= 1'b1;
                  state_q <= SCAN;
               end
            end
            SCAN: begin
               if (miss_d) begin
                  rom_addr       <= snap_addr_q[ptr_q];
                  rom_sel        <= ptr_q;
                  pipe_vld_q[0]  <= 1'b1;
                  pipe_keep_q[0] <= ~invalidate;
                  pipe_idx_q[0]  <= ptr_q;
                  pipe_addr_q[0] <= snap_addr_q[ptr_q];
               end
               if (last_d) begin
                  cnt_q   <= '0;
                  state_q <= DRAIN;
               end else begin
                  ptr_q <= ptr_q + 1'b1;
               end
            end
            DRAIN: begin
               if (cnt_q == 2'(RLAT - 1)) begin
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase

         // Only a ph2 that lands outside IDLE is lost; the done cycle is already IDLE.
         if (ph2 && (state_q != IDLE)) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ieee_rom_arbiter.sv
// Directed bench for ieee_rom_arbiter: one instance with RLAT=1 and one with RLAT=3 share stimulus.
// Each ROM model returns {addr[11:8], addr[3:0]} after the instance's read latency.
module tb_ieee_rom_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        ph2;
   logic [3:0]  cliEn;
   logic [55:0] cliAddr;
   logic        invalidate;

   logic [13:0] romAddr1, romAddr3;
   logic [1:0]  romSel1, romSel3;
   logic [7:0]  romQ1, romQ3;
   logic [31:0] cliData1, cliData3;
   logic [3:0]  cliValid1, cliValid3;
   logic        busy1, busy3, done1, done3, overrun1, overrun3;
   logic [13:0] romDly1, romDly2;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   ieee_rom_arbiter #(.NCLI(4), .AW(14), .DW(8), .RLAT(1)) u_dut1 (
      .clk_sys(clk), .reset(reset), .ph2(ph2), .cli_en(cliEn), .cli_addr(cliAddr),
      .invalidate(invalidate), .rom_addr(romAddr1), .rom_sel(romSel1), .rom_q(romQ1),
      .cli_data(cliData1), .cli_valid(cliValid1), .busy(busy1), .done(done1),
      .overrun(overrun1));

   ieee_rom_arbiter #(.NCLI(4), .AW(14), .DW(8), .RLAT(3)) u_dut3 (
      .clk_sys(clk), .reset(reset), .ph2(ph2), .cli_en(cliEn), .cli_addr(cliAddr),
      .invalidate(invalidate), .rom_addr(romAddr3), .rom_sel(romSel3), .rom_q(romQ3),
      .cli_data(cliData3), .cli_valid(cliValid3), .busy(busy3), .done(done3),
      .overrun(overrun3));

   function automatic logic [7:0] romFunc(input logic [13:0] a);
      return {a[11:8], a[3:0]};
   endfunction

   // A 3-cycle ROM is modelled as two address registers in front of the lookup.
   always @(posedge clk) begin
      romDly1 <= romAddr3;
      romDly2 <= romDly1;
   end
   assign romQ1 = romFunc(romAddr1);
   assign romQ3 = romFunc(romDly2);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] en, input logic [13:0] a0,
                                input logic [13:0] a1, input logic [13:0] a2,
                                input logic [13:0] a3);
      cliEn   = en;
      cliAddr = {a3, a2, a1, a0};
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("[TB] miscompare on %s", tag);
      end
   endtask

   initial begin
      reset      = 1'b1;
      ph2        = 1'b0;
      invalidate = 1'b0;
      applyStimulus(4'hF, 14'h0100, 14'h0200, 14'h0300, 14'h0400);
      tick();
      tick();
      checkOutput("rst_rom_addr", 32'(romAddr1), 32'h0);
      checkOutput("rst_rom_sel", 32'(romSel1), 32'h0);
      checkOutput("rst_cli_data", cliData1, 32'h0);
      checkOutput("rst_cli_valid", 32'(cliValid1), 32'h0);
      checkOutput("rst_busy", 32'(busy1), 32'h0);
      checkOutput("rst_done", 32'(done1), 32'h0);
      checkOutput("rst_overrun", 32'(overrun1), 32'h0);
      reset = 1'b0;
      tick();

      // Cold frame: every client misses and is issued in order.
      ph2 = 1'b1; tick(); ph2 = 1'b0;
      checkOutput("f1_e0_busy", 32'(busy1), 32'h1);
      checkOutput("f1_e0_done", 32'(done1), 32'h0);
      tick();
      checkOutput("f1_e1_addr", 32'(romAddr1), 32'h0100);
      checkOutput("f1_e1_sel", 32'(romSel1), 32'h0);
      tick();
      checkOutput("f1_e2_addr", 32'(romAddr1), 32'h0200);
      checkOutput("f1_e2_sel", 32'(romSel1), 32'h1);
      checkOutput("f1_e2_data", cliData1, 32'h0000_0010);
      tick();
      checkOutput("f1_e3_addr", 32'(romAddr1), 32'h0300);
      checkOutput("f1_e3_sel", 32'(romSel1), 32'h2);
      checkOutput("f1_e3_data", cliData1, 32'h0000_2010);
      tick();
      checkOutput("f1_e4_addr", 32'(romAddr1), 32'h0400);
      checkOutput("f1_e4_sel", 32'(romSel1), 32'h3);
      checkOutput("f1_e4_data", cliData1, 32'h0030_2010);
      checkOutput("f1_e4_busy", 32'(busy1), 32'h1);
      checkOutput("f1_e4_done", 32'(done1), 32'h0);
      tick();
      checkOutput("f1_e5_data", cliData1, 32'h4030_2010);
      checkOutput("f1_e5_valid", 32'(cliValid1), 32'hF);
      checkOutput("f1_e5_done", 32'(done1), 32'h1);
      checkOutput("f1_e5_busy", 32'(busy1), 32'h0);
      tick();
      checkOutput("f1_e6_done", 32'(done1), 32'h0);

      // Warm frame with only client 2 moved: a single issue.
      applyStimulus(4'hF, 14'h0100, 14'h0200, 14'h0333, 14'h0400);
      ph2 = 1'b1; tick(); ph2 = 1'b0;
      tick();
      tick();
      checkOutput("f2_e2_addr", 32'(romAddr1), 32'h0400);
      checkOutput("f2_e2_sel", 32'(romSel1), 32'h3);
      tick();
      checkOutput("f2_e3_addr", 32'(romAddr1), 32'h0333);
      checkOutput("f2_e3_sel", 32'(romSel1), 32'h2);
      tick();
      checkOutput("f2_e4_data", cliData1, 32'h4033_2010);
      checkOutput("f2_e4_addr", 32'(romAddr1), 32'h0333);
      checkOutput("f2_e4_done", 32'(done1), 32'h0);
      tick();
      checkOutput("f2_e5_done", 32'(done1), 32'h1);
      checkOutput("f2_e5_data", cliData1, 32'h4033_2010);
      checkOutput("f2_e5_valid", 32'(cliValid1), 32'hF);
      tick();

      // Masked frame after reset: clients 1 and 3 are never fetched.
      reset = 1'b1; tick(); reset = 1'b0;
      checkOutput("rst2_data", cliData1, 32'h0);
      applyStimulus(4'b0101, 14'h0100, 14'h0200, 14'h0300, 14'h0400);
      ph2 = 1'b1; tick(); ph2 = 1'b0;
      tick();
      checkOutput("f3_e1_addr", 32'(romAddr1), 32'h0100);
      tick();
      checkOutput("f3_e2_addr", 32'(romAddr1), 32'h0100);
      checkOutput("f3_e2_sel", 32'(romSel1), 32'h0);
      tick();
      checkOutput("f3_e3_addr", 32'(romAddr1), 32'h0300);
      checkOutput("f3_e3_sel", 32'(romSel1), 32'h2);
      tick();
      checkOutput("f3_e4_sel", 32'(romSel1), 32'h2);
      tick();
      checkOutput("f3_e5_done", 32'(done1), 32'h1);
      checkOutput("f3_e5_valid", 32'(cliValid1), 32'b0101);
      checkOutput("f3_e5_data", cliData1, 32'h0030_0010);
      tick();

      // Stray ph2 mid-frame raises overrun; ph2 during done starts a new frame cleanly.
      applyStimulus(4'hF, 14'h0100, 14'h0200, 14'h0300, 14'h0400);
      ph2 = 1'b1; tick(); ph2 = 1'b0;
      tick();
      tick();
      ph2 = 1'b1; tick(); ph2 = 1'b0;
      checkOutput("f4_e3_overrun", 32'(overrun1), 32'h1);
      checkOutput("f4_e3_busy", 32'(busy1), 32'h1);
      tick();
      tick();
      checkOutput("f4_e5_done", 32'(done1), 32'h1);
      checkOutput("f4_e5_data", cliData1, 32'h4030_2010);
      checkOutput("f4_e5_valid", 32'(cliValid1), 32'hF);
      checkOutput("f4_e5_sel", 32'(romSel1), 32'h3);
      ph2 = 1'b1; tick(); ph2 = 1'b0;
      checkOutput("f5_e0_busy", 32'(busy1), 32'h1);
      checkOutput("f5_e0_done", 32'(done1), 32'h0);
      checkOutput("f5_e0_overrun", 32'(overrun1), 32'h1);
      for (int i = 0; i < 5; i++) tick();
      checkOutput("f5_e5_done", 32'(done1), 32'h1);
      checkOutput("f5_e5_addr", 32'(romAddr1), 32'h0400);
      checkOutput("f5_e5_overrun", 32'(overrun1), 32'h1);
      tick();

      // Three-cycle ROM with invalidate at e2 of a cold frame.
      reset = 1'b1; tick(); reset = 1'b0;
      checkOutput("r3_rst_valid", 32'(cliValid3), 32'h0);
      checkOutput("r3_rst_overrun", 32'(overrun3), 32'h0);
      ph2 = 1'b1; tick(); ph2 = 1'b0;
      tick();
      invalidate = 1'b1; tick(); invalidate = 1'b0;
      tick();
      tick();
      checkOutput("r3_e4_valid", 32'(cliValid3), 32'h0);
      checkOutput("r3_e4_data", cliData3, 32'h0000_0010);
      tick();
      tick();
      checkOutput("r3_e6_done", 32'(done3), 32'h0);
      checkOutput("r3_e6_busy", 32'(busy3), 32'h1);
      checkOutput("r3_e6_valid", 32'(cliValid3), 32'b0100);
      tick();
      checkOutput("r3_e7_done", 32'(done3), 32'h1);
      checkOutput("r3_e7_busy", 32'(busy3), 32'h0);
      checkOutput("r3_e7_valid", 32'(cliValid3), 32'b1100);
      checkOutput("r3_e7_data", cliData3, 32'h4030_2010);
      tick();

      // Reset at e3 of the next frame aborts it with no done pulse.
      ph2 = 1'b1; tick(); ph2 = 1'b0;
      tick();
      tick();
      reset = 1'b1; tick(); reset = 1'b0;
      checkOutput("r3_abort_addr", 32'(romAddr3), 32'h0);
      checkOutput("r3_abort_sel", 32'(romSel3), 32'h0);
      checkOutput("r3_abort_data", cliData3, 32'h0);
      checkOutput("r3_abort_valid", 32'(cliValid3), 32'h0);
      checkOutput("r3_abort_busy", 32'(busy3), 32'h0);
      checkOutput("r3_abort_done", 32'(done3), 32'h0);
      checkOutput("r3_abort_overrun", 32'(overrun3), 32'h0);
      for (int i = 0; i < 8; i++) begin
         tick();
         checkOutput("r3_post_done", 32'(done3), 32'h0);
         checkOutput("r3_post_busy", 32'(busy3), 32'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
